// File: rtl/lsu_pkg.sv
// Shared definitions for the load/store unit: RV32I size codes, FSM states
// and the request legality check.
package lsu_pkg;

  localparam logic [2:0] F3_B  = 3'b000;
  localparam logic [2:0] F3_H  = 3'b001;
  localparam logic [2:0] F3_W  = 3'b010;
  localparam logic [2:0] F3_BU = 3'b100;
  localparam logic [2:0] F3_HU = 3'b101;

  typedef enum logic [2:0] {
    IDLE  = 3'd0,
    RD    = 3'd1,
    LD    = 3'd2,
    MERGE = 3'd3,
    WR    = 3'd4,
    RESP  = 3'd5,
    ERR   = 3'd6
  } lsu_state_e;

  // Rejects unknown size codes for the access direction and unaligned H/W accesses.
  function automatic logic req_error(input logic       write,
                                     input logic [2:0] funct3,
                                     input logic [1:0] offset);
    logic legal;
    logic misaligned;
    if (write)
      legal = (funct3 == F3_B) || (funct3 == F3_H) || (funct3 == F3_W);
    else
      legal = (funct3 == F3_B) || (funct3 == F3_H) || (funct3 == F3_W) ||
              (funct3 == F3_BU) || (funct3 == F3_HU);
    misaligned = ((funct3[1:0] == 2'b01) && offset[0]) ||
                 ((funct3[1:0] == 2'b10) && (offset != 2'b00));
    return !legal || misaligned;
  endfunction

endpackage

// File: rtl/lsu_if.sv
// Request/response handshake plus the word-addressed memory port of the LSU.
interface lsu_if #(
  parameter int ADDR_WIDTH = 10
);
  logic                  req_valid;
  logic                  req_ready;
  logic                  req_write;
  logic [2:0]            req_funct3;
  logic [31:0]           req_addr;
  logic [31:0]           req_wdata;
  logic                  resp_valid;
  logic [31:0]           resp_rdata;
  logic                  resp_misaligned;
  logic                  mem_read;
  logic                  mem_write;
  logic [ADDR_WIDTH-1:0] mem_address;
  logic [31:0]           mem_write_data;
  logic [31:0]           mem_read_data;

  // master: execute stage plus the memory it talks to; slave: the LSU itself
  modport master (
    output req_valid, req_write, req_funct3, req_addr, req_wdata, mem_read_data,
    input  req_ready, resp_valid, resp_rdata, resp_misaligned,
           mem_read, mem_write, mem_address, mem_write_data
  );

  modport slave (
    input  req_valid, req_write, req_funct3, req_addr, req_wdata, mem_read_data,
    output req_ready, resp_valid, resp_rdata, resp_misaligned,
           mem_read, mem_write, mem_address, mem_write_data
  );
endinterface

// File: rtl/lsu_lane_align.sv
// Byte/half lane handling: load extraction with sign/zero extension, and the
// read-modify-write merge used for SB/SH since the memory has no byte enables.
module lsu_lane_align
  import lsu_pkg::*;
(
  input  logic [31:0] i_word,
  input  logic [31:0] i_wdata,
  input  logic [1:0]  i_offset,
  input  logic [2:0]  i_funct3,
  output logic [31:0] o_load_data,
  output logic [31:0] o_merge_data
);

  function automatic logic [31:0] load_extract(input logic [31:0] word,
                                               input logic [1:0]  offset,
                                               input logic [2:0]  funct3);
    logic [7:0]  b;
    logic [15:0] h;
    case (offset)
      2'd0:    b = word[7:0];
      2'd1:    b = word[15:8];
      2'd2:    b = word[23:16];
      default: b = word[31:24];
    endcase
    h = offset[1] ? word[31:16] : word[15:0];
    case (funct3)
      F3_B:    return {{24{b[7]}}, b};
      F3_BU:   return {24'd0, b};
      F3_H:    return {{16{h[15]}}, h};
      F3_HU:   return {16'd0, h};
      default: return word;
    endcase
  endfunction

  function automatic logic [31:0] store_merge(input logic [31:0] old_word,
                                              input logic [31:0] wdata,
                                              input logic [1:0]  offset,
                                              input logic [2:0]  funct3);
    logic [31:0] m;
    m = old_word;
    case (funct3)
      F3_B: begin
        case (offset)
          2'd0:    m[7:0]   = wdata[7:0];
          2'd1:    m[15:8]  = wdata[7:0];
          2'd2:    m[23:16] = wdata[7:0];
          default: m[31:24] = wdata[7:0];
        endcase
      end
      F3_H: begin
        if (offset[1]) m[31:16] = wdata[15:0];
        else           m[15:0]  = wdata[15:0];
      end
      default: m = wdata;
    endcase
    return m;
  endfunction

  assign o_load_data  = load_extract(i_word, i_offset, i_funct3);
  assign o_merge_data = store_merge(i_word, i_wdata, i_offset, i_funct3);

endmodule

// File: rtl/load_store_unit.sv
// RV32I load/store initiator for a word-addressed, registered-read memory.
// One request in flight; responses are registered one-cycle pulses.
module load_store_unit
  import lsu_pkg::*;
#(
  parameter int DATA_WIDTH = 32,
  parameter int ADDR_WIDTH = 10
) (
  input  logic clk,
  input  logic rst,
  lsu_if.slave bus
);

  lsu_state_e              r_state;
  lsu_state_e              w_next;
  logic                    w_accept;
  logic                    r_write;
  logic [2:0]              r_funct3;
  logic [1:0]              r_offset;
  logic [ADDR_WIDTH-1:0]   r_word_addr;
  logic [DATA_WIDTH-1:0]   r_wdata;
  logic [DATA_WIDTH-1:0]   r_ld_data;
  logic                    r_resp_valid;
  logic [DATA_WIDTH-1:0]   r_resp_rdata;
  logic                    r_resp_mis;
  logic [DATA_WIDTH-1:0]   w_load_data;
  logic [DATA_WIDTH-1:0]   w_merge_data;

  lsu_lane_align u_align (
    .i_word       (bus.mem_read_data),
    .i_wdata      (r_wdata),
    .i_offset     (r_offset),
    .i_funct3     (r_funct3),
    .o_load_data  (w_load_data),
    .o_merge_data (w_merge_data)
  );

  always_ff @(posedge clk or posedge rst) begin
    if (rst) r_state <= IDLE;
    else     r_state <= w_next;
  end

  always_comb begin
    w_next   = r_state;
    w_accept = bus.req_valid && (r_state == IDLE);
    case (r_state)
      IDLE: begin
        if (w_accept) begin
          if (req_error(bus.req_write, bus.req_funct3, bus.req_addr[1:0]))
            w_next = ERR;
          else if (bus.req_write && (bus.req_funct3 == F3_W))
            w_next = WR;
          else
            w_next = RD;
        end
      end
      RD:      w_next = r_write ? MERGE : LD;
      LD:      w_next = RESP;
      MERGE:   w_next = RESP;
      WR:      w_next = RESP;
      RESP:    w_next = IDLE;
      ERR:     w_next = IDLE;
      default: w_next = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_write      <= 1'b0;
      r_funct3     <= 3'd0;
      r_offset     <= 2'd0;
      r_word_addr  <= '0;
      r_wdata      <= '0;
      r_ld_data    <= '0;
      r_resp_valid <= 1'b0;
      r_resp_rdata <= '0;
      r_resp_mis   <= 1'b0;
    end else begin
      if (w_accept) begin
        r_write     <= bus.req_write;
        r_funct3    <= bus.req_funct3;
        r_offset    <= bus.req_addr[1:0];
        r_word_addr <= bus.req_addr[ADDR_WIDTH+1:2];
        r_wdata     <= bus.req_wdata;
      end
      if (r_state == LD) r_ld_data <= w_load_data;
      // Response lands while the FSM is back in IDLE, so a new request can overlap it
      r_resp_valid <= (r_state == RESP) || (r_state == ERR);
      r_resp_mis   <= (r_state == ERR);
      r_resp_rdata <= ((r_state == RESP) && !r_write) ? r_ld_data : '0;
    end
  end

  assign bus.req_ready       = (r_state == IDLE);
  assign bus.resp_valid      = r_resp_valid;
  assign bus.resp_rdata      = r_resp_rdata;
  assign bus.resp_misaligned = r_resp_mis;

  // Memory strobes come from registered state only; async reset kills them at once
  assign bus.mem_read       = (r_state == RD);
  assign bus.mem_write      = (r_state == MERGE) || (r_state == WR);
  assign bus.mem_address    = r_word_addr;
  assign bus.mem_write_data = (r_state == MERGE) ? w_merge_data :
                              (r_state == WR)    ? r_wdata      : '0;

endmodule

// File: tb/tb_load_store_unit.sv
// Directed bench for load_store_unit with a registered-read word memory model.
module tb_load_store_unit;
  localparam int AW = 10;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  lsu_if #(.ADDR_WIDTH(AW)) bus ();

  load_store_unit #(.DATA_WIDTH(32), .ADDR_WIDTH(AW)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  logic [31:0] mem [0:(1<<AW)-1];
  always @(posedge clk) begin
    if (bus.mem_write) mem[bus.mem_address] <= bus.mem_write_data;
    if (bus.mem_read)  bus.mem_read_data <= mem[bus.mem_address];
  end

  int          n_rd = 0, n_wr = 0, n_both = 0;
  logic [31:0] last_wd = '0;
  logic [AW-1:0] last_wa = '0;
  always @(negedge clk) begin
    if (bus.mem_read) n_rd <= n_rd + 1;
    if (bus.mem_write) begin
      n_wr    <= n_wr + 1;
      last_wd <= bus.mem_write_data;
      last_wa <= bus.mem_address;
    end
    if (bus.mem_read && bus.mem_write) n_both <= n_both + 1;
  end

  int n_chk = 0;
  int n_err = 0;
  logic        first_mw;
  logic [31:0] first_ma;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got=%h expected=%h", tag, got, exp);
    end
  endtask

  // Called #1 after a rising edge; issues one request and checks its response.
  task automatic lsu_op(input string tag, input logic wr, input logic [2:0] f3,
                        input logic [31:0] addr, input logic [31:0] wd,
                        input int exp_lat, input logic [31:0] exp_rd, input logic exp_mis);
    int          lat;
    logic [31:0] got_rd;
    logic        got_mis;
    check({tag, "_ready"}, {31'd0, bus.req_ready}, 32'd1);
    bus.req_valid  = 1'b1;
    bus.req_write  = wr;
    bus.req_funct3 = f3;
    bus.req_addr   = addr;
    bus.req_wdata  = wd;
    @(posedge clk); #1;
    bus.req_valid = 1'b0;
    first_mw = bus.mem_write;
    first_ma = 32'(bus.mem_address);
    lat     = -1;
    got_rd  = 32'hX;
    got_mis = 1'bX;
    for (int k = 1; k <= 6 && lat < 0; k++) begin
      @(posedge clk); #1;
      if (bus.resp_valid) begin
        lat     = k;
        got_rd  = bus.resp_rdata;
        got_mis = bus.resp_misaligned;
      end
    end
    check({tag, "_lat"}, 32'(lat), 32'(exp_lat));
    check({tag, "_rdata"}, got_rd, exp_rd);
    check({tag, "_mis"}, {31'd0, got_mis}, {31'd0, exp_mis});
    @(posedge clk); #1;
    check({tag, "_pulse"}, {31'd0, bus.resp_valid}, 32'd0);
  endtask

  task automatic err_op(input string tag, input logic wr, input logic [2:0] f3,
                        input logic [31:0] addr);
    int rd0, wr0;
    rd0 = n_rd;
    wr0 = n_wr;
    lsu_op(tag, wr, f3, addr, 32'hFFFF_FFFF, 1, 32'd0, 1'b1);
    check({tag, "_noacc"}, 32'((n_rd - rd0) + (n_wr - wr0)), 32'd0);
  endtask

  initial begin
    int seen;
    bus.req_valid  = 1'b0;
    bus.req_write  = 1'b0;
    bus.req_funct3 = 3'd0;
    bus.req_addr   = '0;
    bus.req_wdata  = '0;
    repeat (2) @(posedge clk);
    #1;
    check("rst_resp_valid", {31'd0, bus.resp_valid}, 32'd0);
    check("rst_resp_rdata", bus.resp_rdata, 32'd0);
    check("rst_resp_mis", {31'd0, bus.resp_misaligned}, 32'd0);
    check("rst_mem_rw", {30'd0, bus.mem_read, bus.mem_write}, 32'd0);
    check("rst_mem_addr", 32'(bus.mem_address), 32'd0);
    check("rst_mem_wdata", bus.mem_write_data, 32'd0);
    rst = 1'b0;
    @(posedge clk); #1;
    check("rst_ready", {31'd0, bus.req_ready}, 32'd1);

    lsu_op("sw8", 1'b1, 3'b010, 32'h8, 32'hDEADBEEF, 2, 32'd0, 1'b0);
    check("sw8_mw", {31'd0, first_mw}, 32'd1);
    check("sw8_ma", first_ma, 32'd2);
    lsu_op("lw8", 1'b0, 3'b010, 32'h8, 32'd0, 3, 32'hDEADBEEF, 1'b0);

    lsu_op("sw8b", 1'b1, 3'b010, 32'h8, 32'h80FF7F01, 2, 32'd0, 1'b0);
    lsu_op("lb8",  1'b0, 3'b000, 32'h8, 32'd0, 3, 32'h00000001, 1'b0);
    lsu_op("lbA",  1'b0, 3'b000, 32'hA, 32'd0, 3, 32'hFFFFFFFF, 1'b0);
    lsu_op("lbuB", 1'b0, 3'b100, 32'hB, 32'd0, 3, 32'h00000080, 1'b0);
    lsu_op("lhA",  1'b0, 3'b001, 32'hA, 32'd0, 3, 32'hFFFF80FF, 1'b0);
    lsu_op("lhu8", 1'b0, 3'b101, 32'h8, 32'd0, 3, 32'h00007F01, 1'b0);

    lsu_op("swC", 1'b1, 3'b010, 32'hC, 32'h11223344, 2, 32'd0, 1'b0);
    lsu_op("sbD", 1'b1, 3'b000, 32'hD, 32'h000000AA, 3, 32'd0, 1'b0);
    check("sbD_wdata", last_wd, 32'h1122AA44);
    check("sbD_waddr", 32'(last_wa), 32'd3);
    lsu_op("shE", 1'b1, 3'b001, 32'hE, 32'h00005566, 3, 32'd0, 1'b0);
    check("shE_wdata", last_wd, 32'h5566AA44);
    lsu_op("lwC", 1'b0, 3'b010, 32'hC, 32'd0, 3, 32'h5566AA44, 1'b0);

    err_op("err_lw6",  1'b0, 3'b010, 32'h6);
    err_op("err_sh5",  1'b1, 3'b001, 32'h5);
    err_op("err_f3_3", 1'b0, 3'b011, 32'h0);
    err_op("err_sb4",  1'b1, 3'b100, 32'h0);

    // Back-to-back: LW 0x8 then SW 0x10 with req_valid held throughout
    bus.req_valid  = 1'b1;
    bus.req_write  = 1'b0;
    bus.req_funct3 = 3'b010;
    bus.req_addr   = 32'h8;
    bus.req_wdata  = 32'h0;
    @(posedge clk); #1;
    bus.req_write  = 1'b1;
    bus.req_addr   = 32'h10;
    bus.req_wdata  = 32'h12345678;
    check("b2b_busy", {31'd0, bus.req_ready}, 32'd0);
    seen = -1;
    for (int k = 1; k <= 6 && seen < 0; k++) begin
      @(posedge clk); #1;
      if (bus.resp_valid) seen = k;
    end
    check("b2b_lw_lat", 32'(seen), 32'd3);
    check("b2b_lw_rdata", bus.resp_rdata, 32'h80FF7F01);
    check("b2b_ready", {31'd0, bus.req_ready}, 32'd1);
    @(posedge clk); #1;
    bus.req_valid = 1'b0;
    check("b2b_sw_mw", {31'd0, bus.mem_write}, 32'd1);
    check("b2b_sw_ma", 32'(bus.mem_address), 32'd4);
    check("b2b_sw_wd", bus.mem_write_data, 32'h12345678);
    seen = -1;
    for (int k = 1; k <= 6 && seen < 0; k++) begin
      @(posedge clk); #1;
      if (bus.resp_valid) seen = k;
    end
    check("b2b_sw_lat", 32'(seen), 32'd2);
    check("b2b_sw_rdata", bus.resp_rdata, 32'd0);
    @(posedge clk); #1;

    // Reset while an SB sits in MERGE
    bus.req_valid  = 1'b1;
    bus.req_write  = 1'b1;
    bus.req_funct3 = 3'b000;
    bus.req_addr   = 32'h10;
    bus.req_wdata  = 32'h000000FF;
    @(posedge clk); #1;
    bus.req_valid = 1'b0;
    @(posedge clk); #1;
    check("rstm_in_merge", {31'd0, bus.mem_write}, 32'd1);
    rst = 1'b1;
    #1;
    check("rstm_mw_drop", {31'd0, bus.mem_write}, 32'd0);
    @(posedge clk); #1;
    rst = 1'b0;
    seen = 0;
    for (int k = 0; k < 4; k++) begin
      @(posedge clk); #1;
      if (bus.resp_valid) seen++;
    end
    check("rstm_no_resp", 32'(seen), 32'd0);
    check("rstm_ready", {31'd0, bus.req_ready}, 32'd1);
    lsu_op("rstm_lw10", 1'b0, 3'b010, 32'h10, 32'd0, 3, 32'h12345678, 1'b0);

    lsu_op("wrap_lw", 1'b0, 3'b010, 32'h1008, 32'd0, 3, 32'h80FF7F01, 1'b0);
    check("rd_wr_excl", 32'(n_both), 32'd0);

    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout: got=running expected=finished");
    $fatal(1, "bench timeout");
  end
endmodule
